alu_multicycle: RTL

- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds a 4-bit control field, signed/unsigned compare, XOR/NOR, and iterative multiply and divide that take WIDTH cycles.
- Sits in the execute stage of the multi-cycle datapath. The controller issues an operation with start, stalls on busy, and captures the result on done.

---
 rtl/alu_multicycle.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Registered execute-stage ALU: single-cycle logic/arith/compare ops plus WIDTH-cycle
// shift-add multiply and restoring divide. Define ALU_OVERFLOW_EN to add the Overflow output.
module alu_multicycle #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]  SrcA,
  input  logic [WIDTH-1:0]  SrcB,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  ALUResult,
  output logic              Zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic              Overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(4'b1010);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [CTRL_W-1:0] op_q;
  logic [WIDTH-1:0]  opa_q;    // MUL: shifted multiplicand; DIV: dividend shifting into quotient
  logic [WIDTH-1:0]  opb_q;    // MUL: multiplier shifting right; DIV: constant divisor
  logic [WIDTH-1:0]  acc_q;    // MUL: partial product; DIV: partial remainder
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  result_q;
  logic              done_q;

  logic [WIDTH-1:0]  fast_d;
  logic              fast_ovf_d;
  logic [WIDTH-1:0]  sum_d;
  logic [WIDTH-1:0]  diff_d;
  logic              iter_op_d;

  logic [WIDTH-1:0]  mul_acc_d;
  logic [WIDTH:0]    div_shift_d;
  logic              div_ok_d;
  logic [WIDTH-1:0]  div_rem_d;
  logic [WIDTH-1:0]  div_quo_d;
  logic [WIDTH-1:0]  iter_result_d;

  // Single-cycle result straight from the ports so it lands on the accepting edge.
  always_comb begin
    sum_d      = SrcA + SrcB;
    diff_d     = SrcA - SrcB;
    fast_d     = '0;
    fast_ovf_d = 1'b0;
    iter_op_d  = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU) ||
                 (ALUControl == OP_REMU);
    case (ALUControl)
      OP_AND:  fast_d = SrcA & SrcB;
      OP_OR:   fast_d = SrcA | SrcB;
      OP_ADD: begin
        fast_d     = sum_d;
        fast_ovf_d = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_d[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_NOR:  fast_d = ~(SrcA | SrcB);
      OP_SUB: begin
        fast_d     = diff_d;
        fast_ovf_d = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff_d[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLTU: fast_d = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLT:  fast_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_XOR:  fast_d = SrcA ^ SrcB;
      default: fast_d = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_acc_d   = acc_q + (opb_q[0] ? opa_q : '0);
    div_shift_d = {acc_q, opa_q[WIDTH-1]};
    div_ok_d    = (div_shift_d >= {1'b0, opb_q});
    div_rem_d   = div_ok_d ? WIDTH'(div_shift_d - {1'b0, opb_q}) : div_shift_d[WIDTH-1:0];
    div_quo_d   = {opa_q[WIDTH-2:0], div_ok_d};
    if (op_q == OP_MUL) begin
      iter_result_d = mul_acc_d;
    end else if (op_q == OP_DIVU) begin
      iter_result_d = div_quo_d;
    end else begin
      iter_result_d = div_rem_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q <= ALUControl;
            if (iter_op_d) begin
              state_q <= RUN;
              cnt_q   <= CNT_W'(WIDTH);
              opa_q   <= SrcA;
              opb_q   <= SrcB;
              acc_q   <= '0;
            end else begin
              result_q <= fast_d;
              done_q   <= 1'b1;
`ifdef ALU_OVERFLOW_EN
              ovf_q    <= fast_ovf_d;
`endif
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_d;
            opa_q <= {opa_q[WIDTH-2:0], 1'b0};
            opb_q <= {1'b0, opb_q[WIDTH-1:1]};
          end else begin
            acc_q <= div_rem_d;
            opa_q <= div_quo_d;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= IDLE;
            result_q <= iter_result_d;
            done_q   <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign ALUResult = result_q;
  assign Zero      = (result_q == '0);
`ifdef ALU_OVERFLOW_EN
  assign Overflow  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = fast_ovf_d;
`endif

endmodule
